// File: rtl/fetch_prefetch_queue.sv
// rtl/fetch_prefetch_queue.sv - byte-wise instruction fetch FSM feeding a small instruction/PC prefetch FIFO
// Assembles big-endian 16-bit instructions from two byte reads and queues them for decode.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     CK,
  input  logic                     RST,
  output logic                     MEM_REQ,
  output logic [15:0]              MEM_ADDR,
  input  logic [7:0]               MEM_RDATA,
  input  logic                     MEM_ACK,
  input  logic                     REDIR,
  input  logic [15:0]              REDIR_PC,
  output logic [15:0]              IR,
  output logic [15:0]              IR_PC,
  output logic                     IR_VALID,
  input  logic                     IR_READY,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic {ST_HI, ST_LO} state_e;

  state_e        state_q, state_d;
  logic [15:0]   pc_q, pc_d;
  logic [7:0]    hi_q, hi_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   ir_mem_q [DEPTH];
  logic [15:0]   pc_mem_q [DEPTH];
  logic          push, pop;

  // Request depends only on registered state, except that reset and redirect suppress it.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hi_d     = hi_q;
    push     = 1'b0;
    MEM_ADDR = (state_q == ST_LO) ? pc_q + 16'd1 : pc_q;
    MEM_REQ  = 1'b0;
    if (!RST && !REDIR) begin
      MEM_REQ = (state_q == ST_LO) || (count_q != DEPTH_C);
    end
    if (REDIR) begin
      state_d = ST_HI;
      pc_d    = {REDIR_PC[15:1], 1'b0};
    end else if (MEM_REQ && MEM_ACK) begin
      if (state_q == ST_HI) begin
        hi_d    = MEM_RDATA;
        state_d = ST_LO;
      end else begin
        push    = 1'b1;
        pc_d    = pc_q + 16'd2;
        state_d = ST_HI;
      end
    end
  end

  assign IR_VALID = (count_q != '0);
  assign pop      = IR_VALID && IR_READY && !REDIR;
  assign COUNT    = count_q;
  assign IR       = IR_VALID ? ir_mem_q[rd_ptr_q] : 16'h0000;
  assign IR_PC    = IR_VALID ? pc_mem_q[rd_ptr_q] : 16'h0000;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (REDIR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_HI;
      pc_q     <= RESET_PC;
      hi_q     <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hi_q     <= hi_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge CK) begin
    if (push) begin
      ir_mem_q[wr_ptr_q] <= {hi_q, MEM_RDATA};
      pc_mem_q[wr_ptr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb/tb_fetch_prefetch_queue.sv - self-checking bench for fetch_prefetch_queue with a queue-based reference model
module tb_fetch_prefetch_queue;

  localparam int DEPTH = 4;

  logic        CK = 1'b0;
  logic        RST = 1'b1;
  logic        MEM_ACK = 1'b0, REDIR = 1'b0, IR_READY = 1'b0;
  logic [15:0] REDIR_PC = 16'h0000;
  logic        MEM_REQ, IR_VALID;
  logic [15:0] MEM_ADDR, IR, IR_PC;
  logic [7:0]  MEM_RDATA;
  logic [2:0]  COUNT;

  logic        MEM_REQ2, IR_VALID2;
  logic [15:0] MEM_ADDR2, IR2, IR_PC2;
  logic [7:0]  MEM_RDATA2;
  logic [2:0]  COUNT2;

  logic [7:0]  mem [0:65535];
  assign MEM_RDATA  = mem[MEM_ADDR];
  assign MEM_RDATA2 = mem[MEM_ADDR2];

  always #5 CK = ~CK;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .CK(CK), .RST(RST), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK), .REDIR(REDIR), .REDIR_PC(REDIR_PC), .IR(IR), .IR_PC(IR_PC),
    .IR_VALID(IR_VALID), .IR_READY(IR_READY), .COUNT(COUNT));

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'hFFFE)) dut2 (
    .CK(CK), .RST(RST), .MEM_REQ(MEM_REQ2), .MEM_ADDR(MEM_ADDR2), .MEM_RDATA(MEM_RDATA2),
    .MEM_ACK(MEM_ACK), .REDIR(REDIR), .REDIR_PC(REDIR_PC), .IR(IR2), .IR_PC(IR_PC2),
    .IR_VALID(IR_VALID2), .IR_READY(IR_READY), .COUNT(COUNT2));

  int tests = 0;
  int fails = 0;

  // Reference model: fetch pointer, byte phase, and a queue of {pc, instruction}.
  logic [15:0] m_pc;
  logic        m_phase;
  logic [7:0]  m_hi;
  logic [31:0] m_q [$];

  logic [52:0] dut_out;
  assign dut_out = {MEM_REQ, MEM_ADDR, IR_VALID, IR, IR_PC, COUNT};

  function automatic logic [52:0] model_out();
    logic v;
    logic r;
    logic [15:0] ir, ipc;
    v   = (m_q.size() != 0);
    r   = !RST && !REDIR && (m_phase || (m_q.size() < DEPTH));
    ir  = v ? m_q[0][15:0]  : 16'h0000;
    ipc = v ? m_q[0][31:16] : 16'h0000;
    return {r, m_pc + {15'd0, m_phase}, v, ir, ipc, 3'(m_q.size())};
  endfunction

  task automatic model_reset(input logic [15:0] rpc);
    m_q.delete();
    m_pc    = rpc;
    m_phase = 1'b0;
    m_hi    = 8'h00;
  endtask

  task automatic apply(input logic ack, input logic rdy, input logic rd, input logic [15:0] rpc);
    MEM_ACK  = ack;
    IR_READY = rdy;
    REDIR    = rd;
    REDIR_PC = rpc;
    #2;
  endtask

  // Update the model with this cycle's inputs, then move to 1 unit past the next edge.
  task automatic advance();
    logic [52:0] e;
    logic do_pop, do_push;
    logic [31:0] ent;
    e = model_out();
    do_push = 1'b0;
    ent = 32'h0;
    if (REDIR) begin
      model_reset({REDIR_PC[15:1], 1'b0});
    end else begin
      do_pop = (m_q.size() != 0) && IR_READY;
      if (e[52] && MEM_ACK) begin
        if (!m_phase) begin
          m_hi = mem[m_pc];
          m_phase = 1'b1;
        end else begin
          ent = {m_pc, m_hi, mem[m_pc + 16'd1]};
          do_push = 1'b1;
          m_pc = m_pc + 16'd2;
          m_phase = 1'b0;
        end
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(ent);
    end
    @(posedge CK);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] rpc);
    RST = 1'b1;
    MEM_ACK = 1'b0; IR_READY = 1'b0; REDIR = 1'b0;
    model_reset(rpc);
    @(posedge CK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({MEM_REQ, IR_VALID, IR, IR_PC, COUNT} !== 35'h0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b v=%b ir=%h pc=%h cnt=%0d, want all 0", MEM_REQ, IR_VALID, IR, IR_PC, COUNT);
    end
    model_reset(16'h0000);
    @(posedge CK);
    #1;
    RST = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 16'h0);
    tests++;
    if ({MEM_REQ, MEM_ADDR, COUNT} !== {1'b1, 16'h0000, 3'd0}) begin
      fails++;
      $display("FAIL reset_release: got req=%b addr=%h cnt=%0d, want 1 0000 0", MEM_REQ, MEM_ADDR, COUNT);
    end
    advance();
  endtask

  task automatic test_basic();
    logic [31:0] got [$];
    logic [31:0] want [3];
    int first_valid;
    want[0] = {16'h0000, 16'h01A0};
    want[1] = {16'h0002, 16'h0624};
    want[2] = {16'h0004, 16'h0BCC};
    first_valid = -1;
    do_reset(16'h0000);
    for (int c = 0; c < 10; c++) begin
      apply(1'b1, 1'b1, 1'b0, 16'h0);
      tests++;
      if (dut_out !== model_out()) begin
        fails++;
        $display("FAIL basic_cycle%0d: got %h, want %h", c, dut_out, model_out());
      end
      if (IR_VALID && first_valid < 0) first_valid = c;
      if (IR_VALID) got.push_back({IR_PC, IR});
      advance();
    end
    // Cycle index 2 after release is the third sampled cycle.
    tests++;
    if (first_valid != 2) begin
      fails++;
      $display("FAIL basic_latency: got first valid at cycle %0d, want 2", first_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (got.size() <= i || got[i] !== want[i]) begin
        fails++;
        $display("FAIL basic_instr%0d: got %h, want %h", i, (got.size() > i) ? got[i] : 32'hx, want[i]);
      end
    end
  endtask

  task automatic test_full();
    do_reset(16'h0000);
    for (int c = 0; c < 14; c++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0);
      tests++;
      if (dut_out !== model_out()) begin
        fails++;
        $display("FAIL full_cycle%0d: got %h, want %h", c, dut_out, model_out());
      end
      advance();
    end
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    tests++;
    if ({COUNT, MEM_REQ, MEM_ADDR} !== {3'd4, 1'b0, 16'h0008}) begin
      fails++;
      $display("FAIL full_stall: got cnt=%0d req=%b addr=%h, want 4 0 0008", COUNT, MEM_REQ, MEM_ADDR);
    end
    advance();
    apply(1'b1, 1'b1, 1'b0, 16'h0);
    advance();
    apply(1'b0, 1'b0, 1'b0, 16'h0);
    tests++;
    if ({COUNT, MEM_REQ, MEM_ADDR} !== {3'd3, 1'b1, 16'h0008}) begin
      fails++;
      $display("FAIL full_resume: got cnt=%0d req=%b addr=%h, want 3 1 0008", COUNT, MEM_REQ, MEM_ADDR);
    end
    advance();
  endtask

  task automatic test_stall();
    logic [31:0] got [$];
    logic [16:0] prev;
    logic prev_wait;
    int max_cnt;
    prev_wait = 1'b0;
    prev = '0;
    max_cnt = 0;
    do_reset(16'h0000);
    for (int c = 0; c < 30; c++) begin
      apply((c % 4) == 3, 1'b1, 1'b0, 16'h0);
      tests++;
      if (dut_out !== model_out()) begin
        fails++;
        $display("FAIL stall_cycle%0d: got %h, want %h", c, dut_out, model_out());
      end
      if (prev_wait) begin
        tests++;
        if ({MEM_REQ, MEM_ADDR} !== prev) begin
          fails++;
          $display("FAIL stall_hold%0d: got %h, want %h", c, {MEM_REQ, MEM_ADDR}, prev);
        end
      end
      if (int'(COUNT) > max_cnt) max_cnt = int'(COUNT);
      if (IR_VALID) got.push_back({IR_PC, IR});
      prev = {MEM_REQ, MEM_ADDR};
      prev_wait = MEM_REQ && !MEM_ACK;
      advance();
    end
    tests++;
    if (got.size() < 3 || got[0] !== 32'h0000_01A0 || got[1] !== 32'h0002_0624 || got[2] !== 32'h0004_0BCC) begin
      fails++;
      $display("FAIL stall_seq: got %0d entries first %h, want 01A0/0624/0BCC", got.size(), (got.size() > 0) ? got[0] : 32'hx);
    end
    tests++;
    if (max_cnt > 1) begin
      fails++;
      $display("FAIL stall_count: got max %0d, want <=1", max_cnt);
    end
  endtask

  task automatic test_redirect();
    int c;
    do_reset(16'h0000);
    c = 0;
    while (!(m_phase && m_q.size() == 2) && c < 20) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0);
      tests++;
      if (dut_out !== model_out()) begin
        fails++;
        $display("FAIL redir_fill%0d: got %h, want %h", c, dut_out, model_out());
      end
      advance();
      c++;
    end
    tests++;
    if (c >= 20) begin
      fails++;
      $display("FAIL redir_setup: got timeout, want LO with 2 buffered");
    end
    apply(1'b1, 1'b1, 1'b1, 16'h0011);
    tests++;
    if (MEM_REQ !== 1'b0) begin
      fails++;
      $display("FAIL redir_req: got %b, want 0", MEM_REQ);
    end
    advance();
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    tests++;
    if ({COUNT, IR_VALID, MEM_ADDR, MEM_REQ} !== {3'd0, 1'b0, 16'h0010, 1'b1}) begin
      fails++;
      $display("FAIL redir_flush: got cnt=%0d v=%b addr=%h req=%b, want 0 0 0010 1", COUNT, IR_VALID, MEM_ADDR, MEM_REQ);
    end
    advance();
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    advance();
    apply(1'b0, 1'b0, 1'b0, 16'h0);
    tests++;
    if ({IR_VALID, IR_PC, IR} !== {1'b1, 16'h0010, mem[16'h0010], mem[16'h0011]}) begin
      fails++;
      $display("FAIL redir_target: got v=%b pc=%h ir=%h, want 1 0010 %h%h", IR_VALID, IR_PC, IR, mem[16'h0010], mem[16'h0011]);
    end
    advance();
  endtask

  task automatic test_wrap();
    logic [15:0] want_addr [3];
    want_addr[0] = 16'hFFFE;
    want_addr[1] = 16'hFFFF;
    want_addr[2] = 16'h0000;
    do_reset(16'h0000);
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0);
      tests++;
      if ({MEM_REQ2, MEM_ADDR2} !== {1'b1, want_addr[c]}) begin
        fails++;
        $display("FAIL wrap_addr%0d: got req=%b addr=%h, want 1 %h", c, MEM_REQ2, MEM_ADDR2, want_addr[c]);
      end
      advance();
    end
    apply(1'b0, 1'b0, 1'b0, 16'h0);
    tests++;
    if ({IR_VALID2, IR_PC2, IR2} !== {1'b1, 16'hFFFE, mem[16'hFFFE], mem[16'hFFFF]}) begin
      fails++;
      $display("FAIL wrap_instr: got v=%b pc=%h ir=%h, want 1 FFFE %h%h", IR_VALID2, IR_PC2, IR2, mem[16'hFFFE], mem[16'hFFFF]);
    end
    advance();
  endtask

  task automatic test_async_reset();
    int c;
    do_reset(16'h0000);
    c = 0;
    while (!(m_phase && m_q.size() == 3) && c < 20) begin
      apply(1'b1, 1'b0, 1'b0, 16'h0);
      advance();
      c++;
    end
    tests++;
    if (c >= 20) begin
      fails++;
      $display("FAIL areset_setup: got timeout, want LO with 3 buffered");
    end
    apply(1'b1, 1'b0, 1'b0, 16'h0);
    RST = 1'b1;
    #1;
    tests++;
    if ({MEM_REQ, IR_VALID, COUNT} !== 5'b0) begin
      fails++;
      $display("FAIL areset_immediate: got req=%b v=%b cnt=%0d, want 0 0 0", MEM_REQ, IR_VALID, COUNT);
    end
    model_reset(16'h0000);
    @(posedge CK);
    #1;
    RST = 1'b0;
    apply(1'b1, 1'b1, 1'b0, 16'h0);
    tests++;
    if (dut_out !== model_out() || MEM_ADDR !== 16'h0000 || MEM_REQ !== 1'b1) begin
      fails++;
      $display("FAIL areset_restart: got %h, want %h", dut_out, model_out());
    end
    advance();
  endtask

  task automatic test_random();
    logic rd;
    rd = 1'b0;
    do_reset(16'h0000);
    for (int c = 0; c < 1500; c++) begin
      rd = ($urandom_range(0, 29) == 0) || (rd && $urandom_range(0, 1) == 1);
      apply($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, rd, 16'($urandom));
      tests++;
      if (dut_out !== model_out()) begin
        fails++;
        $display("FAIL random_cycle%0d: got %h, want %h", c, dut_out, model_out());
      end
      advance();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h01; mem[1] = 8'hA0; mem[2] = 8'h06;
    mem[3] = 8'h24; mem[4] = 8'h0B; mem[5] = 8'hCC;
    test_reset();
    test_basic();
    test_full();
    test_stall();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
